// File: rtl/switcher_arb_pkg.sv
// Shared constants and types for the switcher arbiter and its helpers.
package switcher_arb_pkg;
    localparam int NREQ    = 8;
    localparam int SEL_W   = $clog2(NREQ);
    localparam int BEATS_W = 8;

    typedef enum logic {
        IDLE = 1'b0,
        OWN  = 1'b1
    } state_t;
endpackage

// File: rtl/switcher_arb_rr_pick.sv
// Combinational round-robin picker: first requester at or after prio, modulo N.
module rr_pick #(
    parameter int N = 8,
    parameter int W = $clog2(N)
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] prio,
    output logic [W-1:0] winner,
    output logic         valid
);
    logic [W-1:0] idx;

    always_comb begin
        winner = '0;
        valid  = 1'b0;
        idx    = '0;
        for (int k = 0; k < N; k++) begin
            idx = W'((int'(prio) + k) % N);
            if (!valid && req[idx]) begin
                winner = idx;
                valid  = 1'b1;
            end
        end
    end
endmodule

// File: rtl/switcher_arbiter.sv
// Round-robin owner/burst sequencer driving the 8-way switcher select.
module switcher_arbiter
    import switcher_arb_pkg::*;
#(
    parameter int MAX_BURST = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NREQ-1:0]    req,
    input  logic               ack,
    output logic [NREQ-1:0]    gnt,
    output logic [SEL_W-1:0]   sel,
    output logic               busy,
    output logic [BEATS_W-1:0] beats,
    output state_t             dbg_state,
    output logic [SEL_W-1:0]   dbg_prio
);
    state_t             state_q, state_d;
    logic [SEL_W-1:0]   prio;
    logic [SEL_W-1:0]   winner;
    logic               winner_valid;
    logic               beat;
    logic               release_own;

    rr_pick #(.N(NREQ), .W(SEL_W)) u_pick (
        .req    (req),
        .prio   (prio),
        .winner (winner),
        .valid  (winner_valid)
    );

    // A beat needs the owner still requesting; ACK alone does not count.
    assign beat        = (state_q == OWN) && ack && req[sel];
    assign release_own = (state_q == OWN) &&
                         (!req[sel] || (beat && beats == BEATS_W'(MAX_BURST - 1)));

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (winner_valid) state_d = OWN;
            OWN:     if (release_own)  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            gnt     <= '0;
            sel     <= '0;
            beats   <= '0;
            prio    <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE) begin
                if (winner_valid) begin
                    gnt   <= NREQ'(1) << winner;
                    sel   <= winner;
                    beats <= '0;
                end
            end else if (release_own) begin
                // sel is left alone so the switcher path stays put between grants
                gnt   <= '0;
                prio  <= sel + SEL_W'(1);
                beats <= '0;
            end else if (beat) begin
                beats <= beats + BEATS_W'(1);
            end
        end
    end

    assign busy      = |gnt;
    assign dbg_state = state_q;
    assign dbg_prio  = prio;
endmodule

// File: tb/tb_switcher_arbiter.sv
// Directed-vector bench for switcher_arbiter with MAX_BURST=4.
module tb_switcher_arbiter;
    import switcher_arb_pkg::*;

    logic               clk;
    logic               rst;
    logic [NREQ-1:0]    req;
    logic               ack;
    logic [NREQ-1:0]    gnt;
    logic [SEL_W-1:0]   sel;
    logic               busy;
    logic [BEATS_W-1:0] beats;
    state_t             dbg_state;
    logic [SEL_W-1:0]   dbg_prio;

    int n_checks = 0;
    int n_fail   = 0;

    switcher_arbiter #(.MAX_BURST(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .ack       (ack),
        .gnt       (gnt),
        .sel       (sel),
        .busy      (busy),
        .beats     (beats),
        .dbg_state (dbg_state),
        .dbg_prio  (dbg_prio)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle(input string tag, input logic [SEL_W-1:0] exp_sel,
                              input logic [SEL_W-1:0] exp_prio);
        check({tag, "_gnt"},   32'(gnt), 32'h0);
        check({tag, "_busy"},  32'(busy), 32'h0);
        check({tag, "_beats"}, 32'(beats), 32'h0);
        check({tag, "_sel"},   32'(sel), 32'(exp_sel));
        check({tag, "_prio"},  32'(dbg_prio), 32'(exp_prio));
    endtask

    task automatic check_own(input string tag, input logic [SEL_W-1:0] owner,
                             input logic [BEATS_W-1:0] exp_beats);
        logic [NREQ-1:0] oh;
        oh = '0;
        oh[owner] = 1'b1;
        check({tag, "_gnt"},   32'(gnt), 32'(oh));
        check({tag, "_sel"},   32'(sel), 32'(owner));
        check({tag, "_busy"},  32'(busy), 32'h1);
        check({tag, "_beats"}, 32'(beats), 32'(exp_beats));
    endtask

    int exp_owner[3] = '{7, 0, 7};

    initial begin
        rst = 1'b1;
        req = '0;
        ack = 1'b0;
        tick();
        tick();
        check_idle("reset", 3'd0, 3'd0);
        check("reset_state", 32'(dbg_state), 32'(IDLE));
        #2 rst = 1'b0;

        // single request, dropped before the burst limit
        req = 8'h04; ack = 1'b1;
        tick(); check_own("single_c0", 3'd2, 8'd0);
        tick(); check_own("single_c1", 3'd2, 8'd1);
        tick(); check_own("single_c2", 3'd2, 8'd2);
        req = 8'h00;
        tick(); check_idle("single_rel", 3'd2, 3'd3);

        // burst limit then re-grant after one bubble
        req = 8'h02;
        tick(); check_own("burst_c0", 3'd1, 8'd0);
        tick(); check_own("burst_c1", 3'd1, 8'd1);
        tick(); check_own("burst_c2", 3'd1, 8'd2);
        tick(); check_own("burst_c3", 3'd1, 8'd3);
        tick(); check_idle("burst_rel", 3'd1, 3'd2);
        tick(); check_own("burst_regnt", 3'd1, 8'd0);
        req = 8'h00;
        tick(); check_idle("burst_drop", 3'd1, 3'd2);

        // fairness between 0 and 7 with pointer wrap
        req = 8'h81;
        for (int g = 0; g < 3; g++) begin
            tick(); check_own($sformatf("rr%0d_c0", g), 3'(exp_owner[g]), 8'd0);
            for (int b = 1; b < 4; b++) begin
                tick(); check_own($sformatf("rr%0d_c%0d", g, b), 3'(exp_owner[g]), 8'(b));
            end
            tick(); check_idle($sformatf("rr%0d_rel", g), 3'(exp_owner[g]),
                               3'((exp_owner[g] + 1) % 8));
        end
        req = 8'h00;
        tick(); check_idle("rr_quiet", 3'd7, 3'd0);

        // ACK gating with owner 5
        req = 8'h20; ack = 1'b0;
        tick(); check_own("ack_c0", 3'd5, 8'd0);
        ack = 1'b1; tick(); check_own("ack_c1", 3'd5, 8'd1);
        ack = 1'b0; tick(); check_own("ack_c2", 3'd5, 8'd1);
        ack = 1'b0; tick(); check_own("ack_c3", 3'd5, 8'd1);
        ack = 1'b1; tick(); check_own("ack_c4", 3'd5, 8'd2);
        ack = 1'b1; tick(); check_own("ack_c5", 3'd5, 8'd3);
        ack = 1'b1; tick(); check_idle("ack_rel", 3'd5, 3'd6);
        req = 8'h00;
        tick(); check_idle("ack_quiet", 3'd5, 3'd6);

        // REQ drop coincident with ACK is not a beat
        req = 8'h08; ack = 1'b1;
        tick(); check_own("drop_c0", 3'd3, 8'd0);
        tick(); check_own("drop_c1", 3'd3, 8'd1);
        tick(); check_own("drop_c2", 3'd3, 8'd2);
        req = 8'h00;
        tick(); check_idle("drop_rel", 3'd3, 3'd4);

        // asynchronous reset between edges
        req = 8'h10; ack = 1'b0;
        tick(); check_own("arst_own", 3'd4, 8'd0);
        ack = 1'b1;
        tick(); check_own("arst_beat", 3'd4, 8'd1);
        #2 rst = 1'b1;
        #1;
        check_idle("arst_now", 3'd0, 3'd0);
        check("arst_state", 32'(dbg_state), 32'(IDLE));
        #1 rst = 1'b0;
        req = 8'hFF; ack = 1'b0;
        tick(); check_own("arst_regnt", 3'd0, 8'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
